// File: rtl/board_input_conditioner_pkg.sv
// board_io_pkg - shared field positions, widths and helpers for the board input conditioner (rev 1.0)
`timescale 1ns/1ps
`default_nettype none

package board_io_pkg;
    localparam int NUM_KEYS       = 4;
    localparam int NUM_SW         = 18;
    localparam int SEQ_W          = 8;
    localparam int CLR_W          = NUM_KEYS + 1;

    localparam int KEY_LVL_LSB    = 0;
    localparam int KEY_STICKY_LSB = 4;
    localparam int KEY_SEQ_LSB    = 8;
    localparam int KEY_OVF_BIT    = 31;
    localparam int SW_CHG_BIT     = 31;
    localparam int CLR_SW_BIT     = 4;

    typedef logic [NUM_KEYS-1:0] key_vec_t;
    typedef logic [NUM_SW-1:0]   sw_vec_t;

    function automatic logic [SEQ_W-1:0] popcount_keys(input key_vec_t v);
        logic [SEQ_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + SEQ_W'(v[i]);
        end
        return n;
    endfunction
endpackage

`default_nettype wire

// File: rtl/board_input_conditioner_if.sv
// board_input_conditioner_if - pin, host-clear and PIO export bundle (rev 1.0)
`timescale 1ns/1ps
`default_nettype none

interface board_input_conditioner_if;
    import board_io_pkg::*;

    key_vec_t           key_n_pin;
    sw_vec_t            sw_pin;
    logic [CLR_W-1:0]   evt_clear;
    logic [31:0]        keys_export;
    logic [31:0]        switchs_export;

    modport master (
        output key_n_pin, sw_pin, evt_clear,
        input  keys_export, switchs_export
    );

    modport slave (
        input  key_n_pin, sw_pin, evt_clear,
        output keys_export, switchs_export
    );
endinterface

`default_nettype wire

// File: rtl/board_input_conditioner_io_debouncer.sv
// io_debouncer - per-bit 2-FF synchroniser and tick-sampled stable counter (rev 1.0)
`timescale 1ns/1ps
`default_nettype none

module io_debouncer #(
    parameter int WIDTH          = 4,
    parameter int STABLE_SAMPLES = 10,
    parameter int CNT_W          = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] flip
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        // flip is the combinational "this tick accepts a new level" strobe
        assign flip[i]  = tick && (sync[i] != lvl) && (cnt == LAST);
        assign level[i] = lvl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (tick) begin
                if (sync[i] == lvl) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    cnt <= '0;
                    lvl <= sync[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/board_input_conditioner.sv
// board_input_conditioner - debounced KEY/SW levels with sticky host-clearable events (rev 1.0)
`timescale 1ns/1ps
`default_nettype none

module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int TICK_CYCLES    = 125000,
    parameter int STABLE_SAMPLES = 10
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    board_input_conditioner_if.slave   io
);
    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CNT_W = $clog2(STABLE_SAMPLES);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [PRE_W-1:0] presc;
    logic             tick;
    logic [CNT_W-1:0] prime_cnt;
    logic             primed;

    key_vec_t         key_level, key_flip, press, sticky;
    sw_vec_t          sw_level, sw_flip;
    logic             sw_change, ovf_set, overflow, sw_changed;
    logic [SEQ_W-1:0] press_seq;
    logic [CLR_W-1:0] clr_q, clr_prev, clr_pulse;
    logic [31:0]      keys_next, sw_next, keys_q, sw_q;

    assign tick = (presc == PRE_LAST);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            presc     <= '0;
            prime_cnt <= '0;
            primed    <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick && !primed) begin
                if (prime_cnt == PRIME_LAST) primed <= 1'b1;
                else                         prime_cnt <= prime_cnt + 1'b1;
            end
        end
    end

    // keys are active-low on the board; inverted so 1 = pressed downstream
    io_debouncer #(.WIDTH(NUM_KEYS), .STABLE_SAMPLES(STABLE_SAMPLES), .CNT_W(CNT_W)) u_keys (
        .clk(clk_clk), .rst(reset_reset), .tick(tick),
        .pin(~io.key_n_pin), .level(key_level), .flip(key_flip)
    );

    io_debouncer #(.WIDTH(NUM_SW), .STABLE_SAMPLES(STABLE_SAMPLES), .CNT_W(CNT_W)) u_sw (
        .clk(clk_clk), .rst(reset_reset), .tick(tick),
        .pin(io.sw_pin), .level(sw_level), .flip(sw_flip)
    );

    // events are taken at the flip edge with the pre-update primed value, so power-up levels never count
    assign press     = primed ? (key_flip & ~key_level) : '0;
    assign sw_change = primed & (|sw_flip);
    assign ovf_set   = |(press & sticky);
    assign clr_pulse = clr_q & ~clr_prev;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            clr_q      <= '0;
            clr_prev   <= '0;
            sticky     <= '0;
            overflow   <= 1'b0;
            sw_changed <= 1'b0;
            press_seq  <= '0;
        end else begin
            clr_q      <= io.evt_clear;
            clr_prev   <= clr_q;
            sticky     <= (sticky & ~clr_pulse[NUM_KEYS-1:0]) | press;
            overflow   <= (overflow & ~clr_pulse[CLR_SW_BIT]) | ovf_set;
            sw_changed <= (sw_changed & ~clr_pulse[CLR_SW_BIT]) | sw_change;
            press_seq  <= press_seq + popcount_keys(press);
        end
    end

    always_comb begin
        keys_next = '0;
        keys_next[KEY_LVL_LSB +: NUM_KEYS]    = key_level;
        keys_next[KEY_STICKY_LSB +: NUM_KEYS] = sticky;
        keys_next[KEY_SEQ_LSB +: SEQ_W]       = press_seq;
        keys_next[KEY_OVF_BIT]                = overflow;
        sw_next = '0;
        sw_next[0 +: NUM_SW]                  = sw_level;
        sw_next[SW_CHG_BIT]                   = sw_changed;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            keys_q <= '0;
            sw_q   <= '0;
        end else begin
            keys_q <= keys_next;
            sw_q   <= sw_next;
        end
    end

    assign io.keys_export    = keys_q;
    assign io.switchs_export = sw_q;
endmodule

`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner - randomized + directed checks against an event-level reference model (rev 1.0)
`timescale 1ns/1ps
`default_nettype none

module tb_board_input_conditioner;
    import board_io_pkg::*;

    localparam int T = 4;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   n_checks = 0;
    int   n_fail   = 0;

    board_input_conditioner_if bus();

    board_input_conditioner #(.TICK_CYCLES(T), .STABLE_SAMPLES(S)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .io          (bus)
    );

    always #5 clk = ~clk;

    // edge index since reset release; tick edges fall on multiples of T
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // reference model: debounced behaviour at the level of settled events
    logic [3:0]  m_key, m_sticky;
    logic [7:0]  m_seq;
    logic        m_ovf, m_chg, m_primed;
    logic [17:0] m_sw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_keys();
        return {m_ovf, 15'd0, m_seq, m_sticky, m_key};
    endfunction

    function automatic logic [31:0] exp_sw();
        return {m_chg, 13'd0, m_sw};
    endfunction

    task automatic model_reset();
        m_key = '0; m_sticky = '0; m_seq = '0; m_ovf = 1'b0;
        m_chg = 1'b0; m_sw = '0; m_primed = 1'b0;
    endtask

    task automatic model_keys(input logic [3:0] pressed);
        for (int i = 0; i < 4; i++) begin
            if (pressed[i] && !m_key[i] && m_primed) begin
                if (m_sticky[i]) m_ovf = 1'b1;
                m_sticky[i] = 1'b1;
                m_seq = m_seq + 8'd1;
            end
        end
        m_key = pressed;
    endtask

    task automatic model_sw(input logic [17:0] lvl);
        if (lvl != m_sw && m_primed) m_chg = 1'b1;
        m_sw = lvl;
    endtask

    task automatic model_clear(input logic [4:0] mask);
        m_sticky = m_sticky & ~mask[3:0];
        if (mask[4]) begin
            m_ovf = 1'b0;
            m_chg = 1'b0;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_keys"}, bus.keys_export, exp_keys());
        check({tag, "_sw"}, bus.switchs_export, exp_sw());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          lat, e0, tk, f_edge, b, len;
        logic [7:0]  seq_before;
        logic [3:0]  p;
        logic [17:0] s;
        logic [4:0]  c;

        rst = 1'b1;
        bus.key_n_pin = 4'b1110;
        bus.sw_pin    = 18'h00005;
        bus.evt_clear = '0;
        model_reset();
        step(3);
        check("reset_keys", bus.keys_export, 32'h0);
        check("reset_sw", bus.switchs_export, 32'h0);
        rst = 1'b0;

        // power-up levels appear without raising any event
        step(40);
        m_primed = 1'b1;
        m_key = 4'b0001;
        m_sw  = 18'h00005;
        check("pwr_keys", bus.keys_export, 32'h00000001);
        check("pwr_sw", bus.switchs_export, 32'h00000005);

        bus.key_n_pin[1] = 1'b0;
        step(6);
        bus.key_n_pin[1] = 1'b1;
        step(20);
        check("glitch_keys", bus.keys_export, 32'h00000001);

        bus.key_n_pin[1] = 1'b0;
        lat = 0;
        while (bus.keys_export[1] == 1'b0 && lat < 40) begin
            step(1);
            lat++;
        end
        check("press_latency", 32'(lat), (lat >= 11 && lat <= 15) ? 32'(lat) : 32'd13);
        check("press_sticky5", 32'(bus.keys_export[5]), 32'd1);
        step(5);
        model_keys(4'b0011);
        check("press_keys", bus.keys_export, 32'h00000123);

        // release key 1, then align the clear pulse with the flip edge of a new press
        bus.key_n_pin = 4'b1110;
        step(20);
        model_keys(4'b0001);
        bus.key_n_pin = 4'b1100;
        e0 = cyc;
        tk = ((e0 + 3 + T - 1) / T) * T;
        f_edge = tk + (S - 1) * T;
        while (cyc < f_edge - 2) step(1);
        bus.evt_clear = 5'b00010;
        step(20);
        model_keys(4'b0011);
        check("set_wins_keys", bus.keys_export, 32'h80000223);
        check("set_wins_model", bus.keys_export, exp_keys());
        bus.evt_clear = '0;
        step(5);
        bus.evt_clear = 5'b10010;
        step(5);
        model_clear(5'b10010);
        check("clear_keys", bus.keys_export, 32'h00000203);
        bus.evt_clear = '0;
        step(3);

        // 256 debounced presses of key 0 wrap press_seq back to its start value
        seq_before = m_seq;
        for (int k = 0; k < 256; k++) begin
            bus.key_n_pin[0] = 1'b1;
            step(18);
            model_keys(~bus.key_n_pin);
            bus.key_n_pin[0] = 1'b0;
            step(18);
            model_keys(~bus.key_n_pin);
        end
        check("wrap_seq", 32'(bus.keys_export[15:8]), 32'(seq_before));
        check("wrap_keys", bus.keys_export, exp_keys());
        check("wrap_sticky_ovf", {30'd0, bus.keys_export[31], bus.keys_export[4]}, 32'h3);

        bus.sw_pin[17] = 1'b1;
        step(20);
        model_sw(bus.sw_pin);
        check("sw_change", bus.switchs_export, 32'h80020005);
        bus.evt_clear[4] = 1'b1;
        step(10);
        model_clear(5'b10000);
        check("sw_clear", bus.switchs_export, 32'h00020005);
        check("sw_clear_keys", bus.keys_export, exp_keys());
        bus.sw_pin[17] = 1'b0;
        step(20);
        model_sw(bus.sw_pin);
        check("clear_once", bus.switchs_export, 32'h80000005);
        bus.evt_clear = '0;
        step(3);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(3, 0))
                0: begin
                    p = 4'($urandom);
                    bus.key_n_pin = ~p;
                    step(20);
                    model_keys(p);
                end
                1: begin
                    b = $urandom_range(3, 0);
                    len = $urandom_range(8, 1);
                    bus.key_n_pin[b] = ~bus.key_n_pin[b];
                    step(len);
                    bus.key_n_pin[b] = ~bus.key_n_pin[b];
                    step(16);
                end
                2: begin
                    s = 18'($urandom);
                    bus.sw_pin = s;
                    step(20);
                    model_sw(s);
                end
                default: begin
                    c = 5'($urandom);
                    bus.evt_clear = c;
                    step(3);
                    bus.evt_clear = '0;
                    step(3);
                    model_clear(c);
                end
            endcase
            check_all("rnd");
        end

        // reset in the middle of key 2's stable count
        bus.key_n_pin = 4'b1111;
        step(20);
        bus.key_n_pin[2] = 1'b0;
        step(7);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_keys", bus.keys_export, 32'h0);
        check("rst_async_sw", bus.switchs_export, 32'h0);
        step(2);
        rst = 1'b0;
        model_reset();
        step(10);
        check("prime_window_keys", bus.keys_export, 32'h0);
        step(10);
        m_primed = 1'b1;
        m_key = 4'b0100;
        m_sw  = bus.sw_pin;
        check("post_rst_keys", bus.keys_export, 32'h00000004);
        check("post_rst_sw", bus.switchs_export, exp_sw());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
